// File: rtl/aes_pkg.sv
// Shared AES types plus the forward and inverse S-box tables (row 0 in the MSBs).
// Table lookup for byte b is TBL[8*(255-b) +: 8].
package aes_pkg;

    localparam int AES_BLOCK_BYTES = 16;

    typedef logic [127:0] aes_block_t;

    typedef enum logic {SBOX_FWD, SBOX_INV} sbox_mode_e;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} sub_state_e;

    localparam logic [2047:0] SBOX_FWD_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [2047:0] SBOX_INV_TBL = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

endpackage

// File: rtl/sbox_lane.sv
// Single-byte dual-mode S-box: purely combinational table lookup,
// no state and no flow control of its own.
module sbox_lane
    import aes_pkg::*;
(
    input  sbox_mode_e  mode,
    input  logic [7:0]  din,
    output logic [7:0]  dout
);

    always_comb begin
        if (mode == SBOX_INV) begin
            dout = SBOX_INV_TBL[8*(255 - int'(din)) +: 8];
        end else begin
            dout = SBOX_FWD_TBL[8*(255 - int'(din)) +: 8];
        end
    end

endmodule

// File: rtl/sub_bytes_engine.sv
// Time-multiplexed AES SubBytes over LANES S-box lanes; result valid BEATS+1 cycles after accept.
// Holds result until out_ready; accepts a new block in the same cycle the result is consumed.
module sub_bytes_engine
    import aes_pkg::*;
#(
    parameter int LANES   = 4,
    parameter bit OUT_REG = 1
) (
    input  logic         clk,
    input  logic         n_rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] data_in,
    input  logic         inv_mode,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] data_out,
    output logic         busy
);

    localparam int BEATS = AES_BLOCK_BYTES / LANES;
    localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;

    if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
        $error("sub_bytes_engine: LANES must be 1, 2, 4, 8 or 16");
    end

    sub_state_e   state, state_nxt;
    logic [CW-1:0] cnt;
    aes_block_t   work_q, work_nxt;
    sbox_mode_e   mode_q;
    logic [7:0]   lane_in  [LANES];
    logic [7:0]   lane_out [LANES];
    logic         accept, last_beat;
    int           base;

    assign accept    = in_valid && in_ready;
    assign last_beat = (cnt == CW'(BEATS - 1));

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid) state_nxt = BUSY;
            BUSY:    if (last_beat) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = in_valid ? BUSY : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state)
            IDLE:    in_ready = n_rst;
            BUSY:    busy = 1'b1;
            DONE: begin
                out_valid = 1'b1;
                in_ready  = n_rst && out_ready;
            end
            default: ;
        endcase
    end

    // Beat k covers bytes k*LANES .. k*LANES+LANES-1, byte 0 being the top byte.
    always_comb begin
        base     = int'(cnt) * LANES;
        work_nxt = work_q;
        for (int i = 0; i < LANES; i++) begin
            lane_in[i] = work_q[8*(AES_BLOCK_BYTES - 1 - base - i) +: 8];
            work_nxt[8*(AES_BLOCK_BYTES - 1 - base - i) +: 8] = lane_out[i];
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        sbox_lane u_lane (
            .mode (mode_q),
            .din  (lane_in[g]),
            .dout (lane_out[g])
        );
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            cnt    <= '0;
            work_q <= '0;
            mode_q <= SBOX_FWD;
        end else if (accept) begin
            cnt    <= '0;
            work_q <= data_in;
            mode_q <= inv_mode ? SBOX_INV : SBOX_FWD;
        end else if (state == BUSY) begin
            work_q <= work_nxt;
            if (!last_beat) begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    if (OUT_REG) begin : g_out_reg
        aes_block_t out_q;
        // Loaded with the fully substituted block on the final beat only.
        always_ff @(posedge clk) begin
            if (!n_rst) begin
                out_q <= '0;
            end else if (state == BUSY && last_beat) begin
                out_q <= work_nxt;
            end
        end
        assign data_out = out_q;
    end else begin : g_out_direct
        assign data_out = work_q;
    end

endmodule

// File: tb/tb_sub_bytes_engine.sv
// Directed bench for sub_bytes_engine: LANES=4 (registered out), LANES=1 (direct out), LANES=16.
module tb_sub_bytes_engine;

    localparam logic [127:0] VEC_PT  = 128'h00102030405060708090a0b0c0d0e0f0;
    localparam logic [127:0] VEC_SB  = 128'h63cab7040953d051cd60e0e7ba70e18c;
    localparam logic [127:0] ALL_63  = {16{8'h63}};
    localparam logic [127:0] ALL_16  = {16{8'h16}};

    logic         clk = 1'b0;
    logic         n_rst;
    logic [127:0] data_in;
    logic         inv_mode;
    logic         iv   [3];
    logic         orr  [3];
    logic         ir   [3];
    logic         ov   [3];
    logic         bz   [3];
    logic [127:0] dout [3];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sub_bytes_engine #(.LANES(4), .OUT_REG(1)) dut4 (
        .clk(clk), .n_rst(n_rst), .in_valid(iv[0]), .in_ready(ir[0]), .data_in(data_in),
        .inv_mode(inv_mode), .out_valid(ov[0]), .out_ready(orr[0]), .data_out(dout[0]), .busy(bz[0])
    );
    sub_bytes_engine #(.LANES(1), .OUT_REG(0)) dut1 (
        .clk(clk), .n_rst(n_rst), .in_valid(iv[1]), .in_ready(ir[1]), .data_in(data_in),
        .inv_mode(inv_mode), .out_valid(ov[1]), .out_ready(orr[1]), .data_out(dout[1]), .busy(bz[1])
    );
    sub_bytes_engine #(.LANES(16), .OUT_REG(1)) dut16 (
        .clk(clk), .n_rst(n_rst), .in_valid(iv[2]), .in_ready(ir[2]), .data_in(data_in),
        .inv_mode(inv_mode), .out_valid(ov[2]), .out_ready(orr[2]), .data_out(dout[2]), .busy(bz[2])
    );

    task automatic test_reset();
        n_rst    = 1'b0;
        data_in  = '0;
        inv_mode = 1'b0;
        for (int d = 0; d < 3; d++) begin
            iv[d]  = 1'b0;
            orr[d] = 1'b0;
        end
        repeat (2) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            checks++; if (ov[d] !== 1'b0) begin errors++; $display("FAIL reset_out_valid[%0d]: got %b want 0", d, ov[d]); end
            checks++; if (bz[d] !== 1'b0) begin errors++; $display("FAIL reset_busy[%0d]: got %b want 0", d, bz[d]); end
            checks++; if (dout[d] !== 128'h0) begin errors++; $display("FAIL reset_data_out[%0d]: got %h want 0", d, dout[d]); end
            checks++; if (ir[d] !== 1'b0) begin errors++; $display("FAIL reset_in_ready_low[%0d]: got %b want 0", d, ir[d]); end
        end
        n_rst = 1'b1;
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            checks++; if (ir[d] !== 1'b1) begin errors++; $display("FAIL idle_in_ready[%0d]: got %b want 1", d, ir[d]); end
        end
    endtask

    task automatic test_forward();
        int n, bc;
        data_in  = VEC_PT;
        inv_mode = 1'b0;
        iv[0]    = 1'b1;
        @(negedge clk);
        iv[0]   = 1'b0;
        data_in = 'x;
        n  = 1;
        bc = (bz[0] === 1'b1) ? 1 : 0;
        while (ov[0] !== 1'b1 && n < 64) begin
            @(negedge clk);
            n++;
            if (bz[0] === 1'b1) bc++;
        end
        checks++; if (n != 5) begin errors++; $display("FAIL fwd_latency: got %0d want 5", n); end
        checks++; if (bc != 4) begin errors++; $display("FAIL fwd_busy_cycles: got %0d want 4", bc); end
        checks++; if (dout[0] !== VEC_SB) begin errors++; $display("FAIL fwd_data: got %h want %h", dout[0], VEC_SB); end
        checks++; if (ir[0] !== 1'b0) begin errors++; $display("FAIL fwd_done_in_ready: got %b want 0", ir[0]); end
        orr[0] = 1'b1;
        #1;
        checks++; if (ir[0] !== 1'b1) begin errors++; $display("FAIL fwd_done_ready_passthru: got %b want 1", ir[0]); end
        @(negedge clk);
        orr[0] = 1'b0;
        checks++; if (ov[0] !== 1'b0) begin errors++; $display("FAIL fwd_consumed: got %b want 0", ov[0]); end
    endtask

    task automatic test_inverse();
        int n, bc, want_lat, want_busy;
        for (int d = 1; d < 3; d++) begin
            want_lat  = (d == 1) ? 17 : 2;
            want_busy = (d == 1) ? 16 : 1;
            data_in  = VEC_SB;
            inv_mode = 1'b1;
            iv[d]    = 1'b1;
            @(negedge clk);
            iv[d]    = 1'b0;
            data_in  = 'x;
            n  = 1;
            bc = (bz[d] === 1'b1) ? 1 : 0;
            while (ov[d] !== 1'b1 && n < 64) begin
                @(negedge clk);
                n++;
                if (bz[d] === 1'b1) bc++;
            end
            checks++; if (n != want_lat) begin errors++; $display("FAIL inv_latency[%0d]: got %0d want %0d", d, n, want_lat); end
            checks++; if (bc != want_busy) begin errors++; $display("FAIL inv_busy_cycles[%0d]: got %0d want %0d", d, bc, want_busy); end
            checks++; if (dout[d] !== VEC_PT) begin errors++; $display("FAIL inv_data[%0d]: got %h want %h", d, dout[d], VEC_PT); end
            orr[d] = 1'b1;
            @(negedge clk);
            orr[d] = 1'b0;
            checks++; if (ov[d] !== 1'b0) begin errors++; $display("FAIL inv_consumed[%0d]: got %b want 0", d, ov[d]); end
        end
    endtask

    task automatic test_backpressure();
        int n;
        data_in  = VEC_SB;
        inv_mode = 1'b1;
        iv[0]    = 1'b1;
        @(negedge clk);
        iv[0] = 1'b0;
        n = 1;
        while (ov[0] !== 1'b1 && n < 64) begin
            @(negedge clk);
            n++;
        end
        checks++; if (n != 5) begin errors++; $display("FAIL bp_latency: got %0d want 5", n); end
        for (int j = 0; j < 10; j++) begin
            iv[0]    = 1'b1;
            inv_mode = ~inv_mode;
            data_in  = {$urandom, $urandom, $urandom, $urandom};
            @(negedge clk);
            checks++; if (dout[0] !== VEC_PT) begin errors++; $display("FAIL bp_hold_data[%0d]: got %h want %h", j, dout[0], VEC_PT); end
            checks++; if (ov[0] !== 1'b1) begin errors++; $display("FAIL bp_hold_valid[%0d]: got %b want 1", j, ov[0]); end
            checks++; if (ir[0] !== 1'b0) begin errors++; $display("FAIL bp_in_ready[%0d]: got %b want 0", j, ir[0]); end
        end
        iv[0]  = 1'b0;
        orr[0] = 1'b1;
        @(negedge clk);
        orr[0] = 1'b0;
        checks++; if (ov[0] !== 1'b0) begin errors++; $display("FAIL bp_consumed: got %b want 0", ov[0]); end
        checks++; if (bz[0] !== 1'b0) begin errors++; $display("FAIL bp_no_accept: busy got %b want 0", bz[0]); end
    endtask

    task automatic test_back_to_back();
        int n;
        data_in  = 128'h0;
        inv_mode = 1'b0;
        iv[0]    = 1'b1;
        orr[0]   = 1'b1;
        @(negedge clk);
        data_in = {16{8'hff}};
        n = 1;
        while (ov[0] !== 1'b1 && n < 64) begin
            @(negedge clk);
            n++;
        end
        checks++; if (n != 5) begin errors++; $display("FAIL b2b_first_latency: got %0d want 5", n); end
        checks++; if (dout[0] !== ALL_63) begin errors++; $display("FAIL b2b_first_data: got %h want %h", dout[0], ALL_63); end
        checks++; if (ir[0] !== 1'b1) begin errors++; $display("FAIL b2b_in_ready_done: got %b want 1", ir[0]); end
        @(negedge clk);
        iv[0] = 1'b0;
        checks++; if (bz[0] !== 1'b1) begin errors++; $display("FAIL b2b_no_idle_gap: busy got %b want 1", bz[0]); end
        n = 1;
        while (ov[0] !== 1'b1 && n < 64) begin
            @(negedge clk);
            n++;
        end
        checks++; if (n != 5) begin errors++; $display("FAIL b2b_second_latency: got %0d want 5", n); end
        checks++; if (dout[0] !== ALL_16) begin errors++; $display("FAIL b2b_second_data: got %h want %h", dout[0], ALL_16); end
        @(negedge clk);
        orr[0] = 1'b0;
        checks++; if (ov[0] !== 1'b0) begin errors++; $display("FAIL b2b_consumed: got %b want 0", ov[0]); end
    endtask

    task automatic test_reset_mid_busy();
        int n;
        data_in  = VEC_PT;
        inv_mode = 1'b0;
        iv[0]    = 1'b1;
        @(negedge clk);
        iv[0] = 1'b0;
        @(negedge clk);
        n_rst = 1'b0;
        @(negedge clk);
        checks++; if (ov[0] !== 1'b0) begin errors++; $display("FAIL rst_mid_out_valid: got %b want 0", ov[0]); end
        checks++; if (bz[0] !== 1'b0) begin errors++; $display("FAIL rst_mid_busy: got %b want 0", bz[0]); end
        checks++; if (dout[0] !== 128'h0) begin errors++; $display("FAIL rst_mid_data: got %h want 0", dout[0]); end
        checks++; if (ir[0] !== 1'b0) begin errors++; $display("FAIL rst_mid_in_ready: got %b want 0", ir[0]); end
        n_rst = 1'b1;
        @(negedge clk);
        checks++; if (ir[0] !== 1'b1) begin errors++; $display("FAIL rst_release_idle: in_ready got %b want 1", ir[0]); end
        checks++; if (ov[0] !== 1'b0) begin errors++; $display("FAIL rst_release_no_output: got %b want 0", ov[0]); end
        data_in = {16{8'hff}};
        iv[0]   = 1'b1;
        @(negedge clk);
        iv[0] = 1'b0;
        n = 1;
        while (ov[0] !== 1'b1 && n < 64) begin
            @(negedge clk);
            n++;
        end
        checks++; if (n != 5) begin errors++; $display("FAIL rst_fresh_latency: got %0d want 5", n); end
        checks++; if (dout[0] !== ALL_16) begin errors++; $display("FAIL rst_fresh_data: got %h want %h", dout[0], ALL_16); end
        orr[0] = 1'b1;
        @(negedge clk);
        orr[0] = 1'b0;
    endtask

    task automatic test_mode_latch();
        int n;
        data_in  = VEC_PT;
        inv_mode = 1'b0;
        iv[0]    = 1'b1;
        @(negedge clk);
        iv[0]    = 1'b0;
        inv_mode = 1'b1;
        data_in  = VEC_SB;
        n = 1;
        while (ov[0] !== 1'b1 && n < 64) begin
            @(negedge clk);
            n++;
        end
        checks++; if (n != 5) begin errors++; $display("FAIL latch_latency: got %0d want 5", n); end
        checks++; if (dout[0] !== VEC_SB) begin errors++; $display("FAIL latch_mode_data: got %h want %h", dout[0], VEC_SB); end
        orr[0] = 1'b1;
        @(negedge clk);
        orr[0] = 1'b0;
        checks++; if (ov[0] !== 1'b0) begin errors++; $display("FAIL latch_consumed: got %b want 0", ov[0]); end
    endtask

    initial begin
        test_reset();
        test_forward();
        test_inverse();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_busy();
        test_mode_latch();
        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
